c2_cfg_loader: RTL and testbench

// - Programs the D00..D11 truth-table inputs of an array of C2 logic cells from a serial bitstream.
// - Gate wrappers tie those inputs to constants; this block loads them at run time, so the cells become reconfigurable.
// - Sits between the external config port and the C2 array. Its output bus drives the D pins directly.

---
 rtl/c2_cfg_loader_pkg.sv | 21 ++
 rtl/c2_cfg_loader_shift_reg.sv | 24 ++
 rtl/c2_cfg_loader.sv | 138 +++++++++++++
 tb/tb_c2_cfg_loader.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/c2_cfg_loader_pkg.sv
// Shared definitions for the C2 configuration loader: FSM states, default
// frame header, and the D-pin layout of one C2 cell.
package c2_cfg_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HEADER = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_COMMIT = 3'd4
   } state_e;

   localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

   localparam int unsigned D00_BIT       = 0;
   localparam int unsigned D01_BIT       = 1;
   localparam int unsigned D10_BIT       = 2;
   localparam int unsigned D11_BIT       = 3;
   localparam int unsigned BITS_PER_CELL = D11_BIT + 1;

endpackage

// File: rtl/c2_cfg_loader_shift_reg.sv
// Serial-in/parallel-out register, MSB-first: each shift moves the contents
// up one place and inserts the new bit at bit 0.
module cfg_shift_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             shift_en_i,
   input  logic             din_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)          q_q <= '0;
      else if (clr_i)       q_q <= '0;
      else if (shift_en_i)  q_q <= {q_q[WIDTH-2:0], din_i};
   end

   assign q_o = q_q;

endmodule

// File: rtl/c2_cfg_loader.sv
// Loads the D00..D11 truth-table inputs of NUM_CELLS C2 cells from a framed,
// parity-protected serial bitstream; the live config changes only on commit.
module c2_cfg_loader
   import c2_cfg_loader_pkg::*;
#(
   parameter int unsigned NUM_CELLS = 8,
   parameter logic [7:0]  HEADER    = HEADER_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   ser_in,
   input  logic                   ser_valid,
   output logic                   ser_ready,
   output logic [4*NUM_CELLS-1:0] cfg_out,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int unsigned    DW        = BITS_PER_CELL * NUM_CELLS;
   localparam int unsigned    CW        = $clog2(DW + 1);
   localparam logic [CW-1:0]  HDR_LAST  = CW'(7);
   localparam logic [CW-1:0]  DATA_LAST = CW'(DW - 1);

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic            par_q;
   logic [DW-1:0]   cfg_q;
   logic            ready_q, busy_q, done_q, err_q;

   logic [7:0]      hdr_q;
   logic [DW-1:0]   shadow_q;
   logic [DW-1:0]   cfg_commit;
   logic            xfer, frame_clr;

   assign xfer      = ser_valid && ready_q;
   assign frame_clr = (state_q == S_IDLE) && start;

   cfg_shift_reg #(.WIDTH(8)) u_hdr_sr (
      .clk_i      (clk),
      .rst_ni     (rst),
      .clr_i      (frame_clr),
      .shift_en_i (xfer && (state_q == S_HEADER)),
      .din_i      (ser_in),
      .q_o        (hdr_q)
   );

   cfg_shift_reg #(.WIDTH(DW)) u_shadow_sr (
      .clk_i      (clk),
      .rst_ni     (rst),
      .clr_i      (frame_clr),
      .shift_en_i (xfer && (state_q == S_DATA)),
      .din_i      (ser_in),
      .q_o        (shadow_q)
   );

   // Cell 0 arrives first, so it ends up in the top nibble of the shadow.
   always_comb begin
      cfg_commit = '0;
      for (int unsigned i = 0; i < NUM_CELLS; i++)
         cfg_commit[i*BITS_PER_CELL +: BITS_PER_CELL] =
            shadow_q[(NUM_CELLS-1-i)*BITS_PER_CELL +: BITS_PER_CELL];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         par_q   <= 1'b0;
         cfg_q   <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: if (start) begin
               state_q <= S_HEADER;
               cnt_q   <= '0;
               ready_q <= 1'b1;
               busy_q  <= 1'b1;
            end
            S_HEADER: if (xfer) begin
               if (cnt_q == HDR_LAST) begin
                  if ({hdr_q[6:0], ser_in} == HEADER) begin
                     state_q <= S_DATA;
                     cnt_q   <= '0;
                     par_q   <= 1'b0;
                  end else begin
                     state_q <= S_IDLE;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b0;
                     err_q   <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_DATA: if (xfer) begin
               par_q <= par_q ^ ser_in;
               if (cnt_q == DATA_LAST) state_q <= S_PARITY;
               else                    cnt_q   <= cnt_q + CW'(1);
            end
            S_PARITY: if (xfer) begin
               ready_q <= 1'b0;
               if (par_q == ser_in) begin
                  state_q <= S_COMMIT;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
               end
            end
            S_COMMIT: begin
               cfg_q   <= cfg_commit;
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ser_ready = ready_q;
   assign cfg_out   = cfg_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_c2_cfg_loader.sv
// Directed bench for c2_cfg_loader with NUM_CELLS=2 and header 8'hA5.
module tb_c2_cfg_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       ser_in = 1'b0;
   logic       ser_valid = 1'b0;
   logic       ser_ready;
   logic [7:0] cfg_out;
   logic       busy, done, err;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   c2_cfg_loader #(.NUM_CELLS(2), .HEADER(8'hA5)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ser_in    (ser_in),
      .ser_valid (ser_valid),
      .ser_ready (ser_ready),
      .cfg_out   (cfg_out),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_bit(input logic b);
      logic        rdy;
      int unsigned w;
      ser_in    = b;
      ser_valid = 1'b1;
      w         = 0;
      do begin
         rdy = ser_ready;
         @(posedge clk); #1;
         w++;
      end while (!rdy && w < 20);
      ser_valid = 1'b0;
      if (!rdy) begin
         n_cmp++; n_bad++;
         $display("FAIL handshake: ser_ready=0 for %0d cycles, required 1", w);
      end
   endtask

   task automatic send_byte(input logic [7:0] v, input logic stall);
      for (int i = 7; i >= 0; i--) begin
         if (stall) begin
            @(posedge clk); #1;
         end
         send_bit(v[i]);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (cfg_out !== 8'h00) begin n_bad++; $display("FAIL rst_cfg: got %h want 00", cfg_out); end
      n_cmp++; if ({busy, ser_ready, done, err} !== 4'b0000) begin n_bad++; $display("FAIL rst_flags: got %b want 0000", {busy, ser_ready, done, err}); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_good_frame();
      pulse_start();
      n_cmp++; if ({busy, ser_ready} !== 2'b11) begin n_bad++; $display("FAIL gf_start: busy,ready=%b want 11", {busy, ser_ready}); end
      send_byte(8'hA5, 1'b0);
      n_cmp++; if ({busy, err} !== 2'b10) begin n_bad++; $display("FAIL gf_hdr: busy,err=%b want 10", {busy, err}); end
      send_byte(8'b1000_1110, 1'b0);
      send_bit(1'b0);
      n_cmp++; if ({done, err, busy, ser_ready} !== 4'b1010) begin n_bad++; $display("FAIL gf_done: done,err,busy,ready=%b want 1010", {done, err, busy, ser_ready}); end
      n_cmp++; if (cfg_out !== 8'h00) begin n_bad++; $display("FAIL gf_cfg_early: got %h want 00", cfg_out); end
      @(posedge clk); #1;
      n_cmp++; if (cfg_out !== 8'hE8) begin n_bad++; $display("FAIL gf_cfg: got %h want e8", cfg_out); end
      n_cmp++; if ({done, busy} !== 2'b00) begin n_bad++; $display("FAIL gf_after: done,busy=%b want 00", {done, busy}); end
   endtask

   task automatic test_bad_parity();
      pulse_start();
      send_byte(8'hA5, 1'b0);
      send_byte(8'b1000_1110, 1'b0);
      send_bit(1'b1);
      n_cmp++; if ({err, done, busy, ser_ready} !== 4'b1000) begin n_bad++; $display("FAIL bp_err: err,done,busy,ready=%b want 1000", {err, done, busy, ser_ready}); end
      @(posedge clk); #1;
      n_cmp++; if ({err, done} !== 2'b00) begin n_bad++; $display("FAIL bp_pulse: err,done=%b want 00", {err, done}); end
      n_cmp++; if (cfg_out !== 8'hE8) begin n_bad++; $display("FAIL bp_cfg: got %h want e8", cfg_out); end
   endtask

   task automatic test_bad_header();
      pulse_start();
      send_byte(8'hA4, 1'b0);
      n_cmp++; if ({err, busy, ser_ready} !== 3'b100) begin n_bad++; $display("FAIL bh_err: err,busy,ready=%b want 100", {err, busy, ser_ready}); end
      ser_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if ({err, busy, ser_ready, done} !== 4'b0000) begin n_bad++; $display("FAIL bh_idle: err,busy,ready,done=%b want 0000", {err, busy, ser_ready, done}); end
      ser_valid = 1'b0;
      n_cmp++; if (cfg_out !== 8'hE8) begin n_bad++; $display("FAIL bh_cfg: got %h want e8", cfg_out); end
   endtask

   task automatic test_reset_in_data();
      pulse_start();
      send_byte(8'hA5, 1'b0);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      pulse_start();
      n_cmp++; if ({busy, ser_ready} !== 2'b11) begin n_bad++; $display("FAIL rd_busy_start: busy,ready=%b want 11", {busy, ser_ready}); end
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (cfg_out !== 8'h00) begin n_bad++; $display("FAIL rd_cfg: got %h want 00", cfg_out); end
      n_cmp++; if ({busy, ser_ready, done, err} !== 4'b0000) begin n_bad++; $display("FAIL rd_flags: got %b want 0000", {busy, ser_ready, done, err}); end
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      pulse_start();
      send_byte(8'hA5, 1'b0);
      send_byte(8'b0110_0110, 1'b0);
      send_bit(1'b0);
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL xor_done: got %b want 1", done); end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++; if (cfg_out !== 8'h66) begin n_bad++; $display("FAIL xor_cfg: got %h want 66", cfg_out); end
      n_cmp++; if ({busy, ser_ready} !== 2'b00) begin n_bad++; $display("FAIL commit_start: busy,ready=%b want 00", {busy, ser_ready}); end
   endtask

   task automatic test_stall();
      pulse_start();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      pulse_start();
      // remaining header bits of A5 after 101: 00101
      for (int i = 4; i >= 0; i--) begin
         @(posedge clk); #1;
         send_bit(i == 2 || i == 0);
      end
      send_byte(8'b1000_1110, 1'b1);
      @(posedge clk); #1;
      n_cmp++; if ({ser_ready, busy, done} !== 3'b110) begin n_bad++; $display("FAIL st_gap: ready,busy,done=%b want 110", {ser_ready, busy, done}); end
      send_bit(1'b0);
      n_cmp++; if ({done, err} !== 2'b10) begin n_bad++; $display("FAIL st_done: done,err=%b want 10", {done, err}); end
      @(posedge clk); #1;
      n_cmp++; if (cfg_out !== 8'hE8) begin n_bad++; $display("FAIL st_cfg: got %h want e8", cfg_out); end
      n_cmp++; if ({done, busy} !== 2'b00) begin n_bad++; $display("FAIL st_after: done,busy=%b want 00", {done, busy}); end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_parity();
      test_bad_header();
      test_reset_in_data();
      test_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
